// File: rtl/stim_pkg.sv
// Shared constants for the stimulus generator:
// sample modes, FSM states, CRC-32 constants.
package stim_pkg;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  function automatic logic [31:0] crc32_bit(
    input logic [31:0] c,
    input logic        b
  );
    crc32_bit = {c[30:0], 1'b0}
              ^ ((c[31] ^ b) ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/stim_gen_if.sv
// Sample stream bus: master drives tdata/tvalid/tlast,
// slave drives tready.
interface stim_gen_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 1
);
  logic [NUM_CH*DATA_W-1:0] m_tdata;
  logic                     m_tvalid;
  logic                     m_tready;
  logic                     m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/stim_lfsr_step.sv
// One combinational Galois right-shift LFSR step.
// s: current state, s_nxt: state after one step.
module stim_lfsr_step #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] LFSR_POLY = 16'hB400
) (
  input  logic [DATA_W-1:0] s,
  output logic [DATA_W-1:0] s_nxt
);
  assign s_nxt = (s >> 1)
               ^ (s[0] ? LFSR_POLY : '0);
endmodule

// File: rtl/stim_gen.sv
// Stimulus generator: ramp/LFSR/const beats on m (master),
// cfg_*/start/abort control, busy/done/beat_cnt status.
// STIM_GEN_CRC_EN adds crc_out (CRC-32 of accepted beats).
module stim_gen
  import stim_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                NUM_CH    = 1,
  parameter int                LEN_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_POLY = 16'hB400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic [DATA_W-1:0] cfg_step,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              start,
  input  logic              abort,
  stim_gen_if.master        m,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  beat_cnt
`ifdef STIM_GEN_CRC_EN
  ,
  output logic [31:0]       crc_out
`endif
);

  localparam int BW = NUM_CH * DATA_W;

  state_t state_q, state_d;

  logic [1:0]        mode_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] step_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              done_q;

  logic [DATA_W-1:0] lfsr_c [NUM_CH+1];
  logic [DATA_W-1:0] ramp_c [NUM_CH];
  logic [BW-1:0]     beat;
  logic [DATA_W-1:0] acc_nxt;

  logic run, launch, xfer, last;
  logic is_ramp, is_lfsr;

  assign run     = (state_q == ST_RUN);
  assign launch  = !run && start && !abort;
  assign xfer    = run && m.m_tready && !abort;
  assign last    = run && (len_q != '0)
                && (cnt_q == len_q - 1'b1);
  assign is_ramp = (mode_q == MODE_RAMP);
  assign is_lfsr = (mode_q == MODE_LFSR);

  assign lfsr_c[0] = acc_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    stim_lfsr_step #(
      .DATA_W   (DATA_W),
      .LFSR_POLY(LFSR_POLY)
    ) u_step (
      .s    (lfsr_c[k]),
      .s_nxt(lfsr_c[k+1])
    );
    assign ramp_c[k] = acc_q
                     + DATA_W'(k) * step_q;
  end

  always_comb begin
    beat    = '0;
    acc_nxt = acc_q;
    unique case (1'b1)
      is_ramp: begin
        for (int k = 0; k < NUM_CH; k++)
          beat[k*DATA_W +: DATA_W] = ramp_c[k];
        acc_nxt = acc_q
                + DATA_W'(NUM_CH) * step_q;
      end
      is_lfsr: begin
        for (int k = 0; k < NUM_CH; k++)
          beat[k*DATA_W +: DATA_W] = lfsr_c[k];
        acc_nxt = lfsr_c[NUM_CH];
      end
      default: begin
        for (int k = 0; k < NUM_CH; k++)
          beat[k*DATA_W +: DATA_W] = acc_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (launch) state_d = ST_RUN;
      ST_RUN:
        if (abort || (xfer && last))
          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_RAMP;
      acc_q  <= '0;
      step_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer && last;
      if (launch) begin
        mode_q <= cfg_mode;
        acc_q  <= cfg_seed;
        step_q <= cfg_step;
        len_q  <= cfg_len;
        cnt_q  <= '0;
      end else if (xfer) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Outputs come straight from state, so they
  // stay stable while the sink stalls.
  assign m.m_tdata  = run ? beat : '0;
  assign m.m_tvalid = run;
  assign m.m_tlast  = last;
  assign busy       = run;
  assign done       = done_q;
  assign beat_cnt   = cnt_q;

`ifdef STIM_GEN_CRC_EN
  logic [31:0] crc_q, crc_nxt;

  always_comb begin
    crc_nxt = crc_q;
    for (int i = BW - 1; i >= 0; i--)
      crc_nxt = crc32_bit(crc_nxt, beat[i]);
  end

  always_ff @(posedge clk) begin
    if (rst || launch) crc_q <= CRC_INIT;
    else if (xfer)     crc_q <= crc_nxt;
  end

  assign crc_out = crc_q;
`endif

endmodule

// File: tb/tb_stim_gen.sv
// Bench for stim_gen: NUM_CH=1 and NUM_CH=4 instances
// on shared controls, checked against a lane-index model.
module tb_stim_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, rdy;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_seed, cfg_step, cfg_len;

  stim_gen_if #(.DATA_W(16), .NUM_CH(1)) if1 ();
  stim_gen_if #(.DATA_W(16), .NUM_CH(4)) if4 ();
  assign if1.m_tready = rdy;
  assign if4.m_tready = rdy;

  logic        busy1, done1, busy4, done4;
  logic [15:0] cnt1, cnt4;
`ifdef STIM_GEN_CRC_EN
  logic [31:0] crc1, crc4;
  logic [31:0] mcrc1, mcrc4;
`endif

  stim_gen #(
    .DATA_W(16), .NUM_CH(1), .LEN_W(16),
    .LFSR_POLY(16'hB400)
  ) dut1 (
    .clk(clk), .rst(rst),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .cfg_step(cfg_step), .cfg_len(cfg_len),
    .start(start), .abort(abort),
    .m(if1),
    .busy(busy1), .done(done1), .beat_cnt(cnt1)
`ifdef STIM_GEN_CRC_EN
    , .crc_out(crc1)
`endif
  );

  stim_gen #(
    .DATA_W(16), .NUM_CH(4), .LEN_W(16),
    .LFSR_POLY(16'hB400)
  ) dut4 (
    .clk(clk), .rst(rst),
    .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .cfg_step(cfg_step), .cfg_len(cfg_len),
    .start(start), .abort(abort),
    .m(if4),
    .busy(busy4), .done(done4), .beat_cnt(cnt4)
`ifdef STIM_GEN_CRC_EN
    , .crc_out(crc4)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  bit          mb, mdone;
  int          mn;
  logic [15:0] mcnt;
  logic [1:0]  mmode;
  logic [15:0] mseed, mstep, mlen;

  function automatic logic [15:0] lfsr_adv(
    input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++)
      s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0);
    return s;
  endfunction

  // Sample number idx of the run, counted
  // across lanes and beats.
  function automatic logic [15:0] lane(input int idx);
    case (mmode)
      2'd0:    return mseed + 16'(idx) * mstep;
      2'd1:    return lfsr_adv(mseed, idx);
      default: return mseed;
    endcase
  endfunction

  function automatic logic [63:0] beat(input int nch);
    logic [63:0] b = '0;
    for (int k = 0; k < nch; k++)
      b[k*16 +: 16] = lane(mn * nch + k);
    return b;
  endfunction

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c, input logic [63:0] d,
    input int nbits);
    for (int i = nbits - 1; i >= 0; i--)
      c = {c[30:0], 1'b0}
        ^ ((c[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    return c;
  endfunction

  function automatic bit mlast();
    return mb && (mlen != 16'd0)
        && (mcnt == mlen - 16'd1);
  endfunction

  task automatic chk(input string tag,
    input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid1", 64'(if1.m_tvalid), 64'(mb));
    chk("valid4", 64'(if4.m_tvalid), 64'(mb));
    chk("data1", 64'(if1.m_tdata),
        mb ? beat(1) : 64'h0);
    chk("data4", 64'(if4.m_tdata),
        mb ? beat(4) : 64'h0);
    chk("last1", 64'(if1.m_tlast), 64'(mlast()));
    chk("last4", 64'(if4.m_tlast), 64'(mlast()));
    chk("busy1", 64'(busy1), 64'(mb));
    chk("busy4", 64'(busy4), 64'(mb));
    chk("done1", 64'(done1), 64'(mdone));
    chk("done4", 64'(done4), 64'(mdone));
    chk("cnt1", 64'(cnt1), 64'(mcnt));
    chk("cnt4", 64'(cnt4), 64'(mcnt));
`ifdef STIM_GEN_CRC_EN
    chk("crc1", 64'(crc1), 64'(mcrc1));
    chk("crc4", 64'(crc4), 64'(mcrc4));
`endif
  endtask

  task automatic mreset();
    mb = 0; mdone = 0; mn = 0; mcnt = '0;
`ifdef STIM_GEN_CRC_EN
    mcrc1 = 32'hFFFFFFFF;
    mcrc4 = 32'hFFFFFFFF;
`endif
  endtask

  // Called at negedge: check, drive, advance model.
  task automatic cyc(input bit r, input bit st,
    input bit ab, input bit rs);
    bit lastv;
    check_all();
    rdy = r; start = st; abort = ab; rst = rs;
    @(posedge clk);
    lastv = mlast();
    mdone = 0;
    if (rs) begin
      mreset();
    end else if (!mb) begin
      if (st && !ab) begin
        mb = 1; mn = 0; mcnt = '0;
        mmode = cfg_mode; mseed = cfg_seed;
        mstep = cfg_step; mlen = cfg_len;
`ifdef STIM_GEN_CRC_EN
        mcrc1 = 32'hFFFFFFFF;
        mcrc4 = 32'hFFFFFFFF;
`endif
      end
    end else if (ab) begin
      mb = 0;
    end else if (r) begin
`ifdef STIM_GEN_CRC_EN
      mcrc1 = crc_upd(mcrc1, beat(1), 16);
      mcrc4 = crc_upd(mcrc4, beat(4), 64);
`endif
      mcnt = mcnt + 16'd1;
      mn++;
      if (lastv) begin
        mb = 0;
        mdone = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic setcfg(input logic [1:0] md,
    input logic [15:0] sd, input logic [15:0] sp,
    input logic [15:0] ln);
    cfg_mode = md; cfg_seed = sd;
    cfg_step = sp; cfg_len = ln;
  endtask

  logic [15:0] t3e [4];
  logic [63:0] b4e [2];

  initial begin
    t3e = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00};
    b4e = '{64'h0003_0002_0001_0000,
            64'h0007_0006_0005_0004};
    rst = 1; start = 0; abort = 0; rdy = 1;
    setcfg(2'd0, 16'd0, 16'd1, 16'd16);
    mmode = 0; mseed = 0; mstep = 0; mlen = 0;
    @(posedge clk);
    @(negedge clk);
    mreset();
    rst = 0;

    // ramp 0..15, sink always ready
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("ramp4_lanes", 64'(if4.m_tdata), b4e[i]);
      cyc(1, 0, 0, 0);
    end
    repeat (17) cyc(1, 0, 0, 0);

    // same run, sink alternates; stray start ignored
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 36; i++)
      cyc(i % 2 == 0, i == 5, 0, 0);

    // LFSR from seed 1, four beats
    setcfg(2'd1, 16'h0001, 16'd0, 16'd4);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("lfsr_seq", 64'(if1.m_tdata), 64'(t3e[i]));
      cyc(1, 0, 0, 0);
    end
    repeat (2) cyc(1, 0, 0, 0);

    // free-run ramp across wrap, then abort
    setcfg(2'd0, 16'hFFFE, 16'd1, 16'd0);
    cyc(1, 1, 0, 0);
    repeat (20) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0);

    // abort beats start in idle
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);

    // reset mid-run, then restart from seed
    setcfg(2'd0, 16'h0100, 16'd3, 16'd16);
    cyc(1, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (19) cyc(1, 0, 0, 0);

    // random configurations and traffic
    repeat (30) begin
      setcfg(2'($urandom_range(0, 3)),
             16'($urandom), 16'($urandom),
             16'($urandom_range(0, 10)));
      cyc(1, 1, 0, 0);
      repeat (25)
        cyc($urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0, 0);
      cyc(1, 0, 1, 0);
      cyc(1, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
